// File: rtl/pipe_hazard_unit.sv
// Hazard, stall and forwarding controller for a 5-stage pipeline.
// Tracks in-flight writes in EX/MEM/WB and drives PC/IF-ID enables, flushes and operand selects.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter bit          FWD_EN   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              byp_a,
    output logic              byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Load flag is only consulted in EX, so MEM/WB entries keep just {v, rd}.
    logic              ex_v_q, ex_v_d, mem_v_q, wb_v_q;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
    logic              ex_ld_q, ex_ld_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic m_ex_a, m_ex_b, m_mem_a, m_mem_b, m_wb_a, m_wb_b;
    logic stall;

    function automatic logic src_match(input logic              valid,
                                       input logic              use_x,
                                       input logic              ent_v,
                                       input logic [REG_AW-1:0] ent_rd,
                                       input logic [REG_AW-1:0] rs);
        return valid && use_x && ent_v && (ent_rd == rs) && !(ZERO_REG && (rs == '0));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic ld);
        if (m_ex && !ld) return 2'b01;
        if (m_mem)       return 2'b10;
        return 2'b00;
    endfunction

    assign m_ex_a  = src_match(id_valid, id_use_rs1, ex_v_q,  ex_rd_q,  id_rs1);
    assign m_ex_b  = src_match(id_valid, id_use_rs2, ex_v_q,  ex_rd_q,  id_rs2);
    assign m_mem_a = src_match(id_valid, id_use_rs1, mem_v_q, mem_rd_q, id_rs1);
    assign m_mem_b = src_match(id_valid, id_use_rs2, mem_v_q, mem_rd_q, id_rs2);
    assign m_wb_a  = src_match(id_valid, id_use_rs1, wb_v_q,  wb_rd_q,  id_rs1);
    assign m_wb_b  = src_match(id_valid, id_use_rs2, wb_v_q,  wb_rd_q,  id_rs2);

    always_comb begin
        if (FWD_EN) stall = (m_ex_a || m_ex_b) && ex_ld_q;
        else        stall = m_ex_a || m_ex_b || m_mem_a || m_mem_b;
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        // A taken branch squashes the stalled instruction, so it takes priority.
        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        ex_v_d  = !id_ex_flush && id_valid && id_reg_wr && !(ZERO_REG && (id_rd == '0));
        ex_rd_d = id_ex_flush ? '0 : id_rd;
        ex_ld_d = !id_ex_flush && id_is_load;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (FWD_EN && !id_ex_flush) begin
            fwd_a_d = fwd_sel(m_ex_a, m_mem_a, ex_ld_q);
            fwd_b_d = fwd_sel(m_ex_b, m_mem_b, ex_ld_q);
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !ex_branch_taken && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_branch_taken && (flush_cnt_q != '1))          flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v_q      <= 1'b0;
            ex_rd_q     <= '0;
            ex_ld_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= '0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            ex_ld_q     <= ex_ld_d;
            mem_v_q     <= ex_v_q;
            mem_rd_q    <= ex_rd_q;
            wb_v_q      <= mem_v_q;
            wb_rd_q     <= mem_rd_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign byp_a     = m_wb_a;
    assign byp_b     = m_wb_b;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: per-cycle vector table on the forwarding instance, plus reset-mid-stall and
// stall-only/saturation sequences on a second instance with FWD_EN=0, CNT_W=2.
module tb_pipe_hazard_unit;

    logic       clk, reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_is_load, ex_branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        pc0, ifen0, iff0, idf0, ba0, bb0;
    logic [1:0]  fa0, fb0;
    logic [15:0] sc0, fc0;
    logic        pc1, ifen1, iff1, idf1, ba1, bb1;
    logic [1:0]  fa1, fb1;
    logic [1:0]  sc1, fc1;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .pc_en(pc0),
        .if_id_en(ifen0), .if_id_flush(iff0), .id_ex_flush(idf0), .fwd_a(fa0), .fwd_b(fb0),
        .byp_a(ba0), .byp_b(bb0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .ZERO_REG(1'b1), .CNT_W(2)) u_stl (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .pc_en(pc1),
        .if_id_en(ifen1), .if_id_flush(iff1), .id_ex_flush(idf1), .fwd_a(fa1), .fwd_b(fb1),
        .byp_a(ba1), .byp_b(bb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {pc_en, if_id_en, if_id_flush, id_ex_flush}
    localparam logic [3:0] N = 4'b1100;
    localparam logic [3:0] S = 4'b0001;
    localparam logic [3:0] B = 4'b1111;

    typedef struct {
        logic        v, u1, u2, wr, ld, br;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ctl;
        logic [1:0]  fa, fb;
        logic        ba, bb;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic br,
                                input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                                input logic ba, input logic bb, input logic [15:0] sc,
                                input logic [15:0] fc);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
        t.wr = wr; t.ld = ld; t.br = br; t.ctl = ctl; t.fa = fa; t.fb = fb;
        t.ba = ba; t.bb = bb; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_wr = wr; id_is_load = ld; ex_branch_taken = br;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int exp_sc;

    initial begin
        // Program on the forwarding instance; one vector per ID cycle.
        tbl[0]  = mk(1, 1, 2, 1, 1,  3, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 0, 0); // ADD r3
        tbl[1]  = mk(1, 3, 1, 1, 1,  5, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 0, 0); // SUB r5=r3-r1
        tbl[2]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, N, 2'b01, 2'b00, 0, 0, 0, 0); // SUB in EX
        tbl[3]  = mk(1, 2, 0, 1, 0,  4, 1, 1, 0, N, 2'b00, 2'b00, 0, 0, 0, 0); // LW r4
        tbl[4]  = mk(1, 4, 4, 1, 1,  6, 1, 0, 0, S, 2'b00, 2'b00, 0, 0, 0, 0); // ADD r6 stalls
        tbl[5]  = mk(1, 4, 4, 1, 1,  6, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0); // released
        tbl[6]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, N, 2'b10, 2'b10, 0, 0, 1, 0); // ADD in EX
        tbl[7]  = mk(1, 1, 0, 1, 0,  7, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0); // write r7
        tbl[8]  = mk(1, 1, 2, 1, 1,  9, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0);
        tbl[9]  = mk(1, 2, 1, 1, 1, 10, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0);
        tbl[10] = mk(1, 7, 0, 1, 0, 11, 1, 0, 0, N, 2'b00, 2'b00, 1, 0, 1, 0); // read r7: bypass
        tbl[11] = mk(1, 1, 0, 1, 0,  0, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0); // write r0
        tbl[12] = mk(1, 0, 0, 1, 1, 12, 1, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0); // read r0
        tbl[13] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 0); // r0 reader in EX
        tbl[14] = mk(1, 1, 0, 1, 0,  4, 1, 1, 0, N, 2'b00, 2'b00, 0, 0, 1, 0); // LW r4
        tbl[15] = mk(1, 4, 0, 1, 0,  6, 1, 0, 1, B, 2'b00, 2'b00, 0, 0, 1, 0); // use + branch
        tbl[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 1);
        tbl[17] = mk(0, 4, 0, 1, 0,  0, 0, 0, 0, N, 2'b00, 2'b00, 0, 0, 1, 1); // invalid ID

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_fwd", {pc0, ifen0, iff0, idf0, fa0, fb0, ba0, bb0, sc0, fc0},
            {N, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0});
        chk("reset_stl", {pc1, ifen1, iff1, idf1, fa1, fb1, ba1, bb1, sc1, fc1},
            {N, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0});
        next_cycle();
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                  tbl[i].wr, tbl[i].ld, tbl[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {pc0, ifen0, iff0, idf0, fa0, fb0, ba0, bb0, sc0, fc0},
                {tbl[i].ctl, tbl[i].fa, tbl[i].fb, tbl[i].ba, tbl[i].bb, tbl[i].sc, tbl[i].fc});
            next_cycle();
        end

        // Reset asserted mid-stall while fwd_a holds 10 and stall_cnt is nonzero.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        drive(1, 1, 0, 1, 0, 4, 1, 1, 0);  // LW r4
        next_cycle();
        drive(1, 4, 0, 1, 0, 6, 1, 1, 0);  // LW r6 <- [r4]: load-use stall
        @(negedge clk);
        chk("rst_seq_stall1", {pc0, idf0}, {1'b0, 1'b1});
        next_cycle();
        next_cycle();                      // same LW r6 proceeds with fwd_a = 10
        drive(1, 6, 0, 1, 0, 7, 1, 0, 0);  // ADD r7 = r6: load-use stall
        @(negedge clk);
        chk("rst_seq_pre", {pc0, idf0, fa0, fb0, sc0}, {1'b0, 1'b1, 2'b10, 2'b00, 16'd1});
        #1 reset = 1'b0;
        #1;
        chk("rst_seq_post", {pc0, ifen0, iff0, idf0, fa0, fb0, ba0, bb0, sc0, fc0},
            {N, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0});
        next_cycle();
        reset = 1'b1;

        // Stall-only instance: ADD r3 then a reader of r3, repeated to saturate stall_cnt.
        exp_sc = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) drive(1, 1, 0, 1, 0, 3, 1, 0, 0);
                else        drive(1, 3, 0, 1, 0, 5, 1, 0, 0);
                @(negedge clk);
                chk($sformatf("stl_p%0d_c%0d", p, c),
                    {pc1, ifen1, iff1, idf1, fa1, fb1, ba1, bb1, sc1, fc1},
                    {((c == 1) || (c == 2)) ? S : N, 2'b00, 2'b00, (c == 3), 1'b0,
                     2'(exp_sc), 2'd0});
                if (((c == 1) || (c == 2)) && (exp_sc < 3)) exp_sc++;
                next_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, stall and forwarding controller for the 5-stage (IF/ID/EX/MEM/WB) pipelined datapath. It replaces the tied-off pipeline register enables (`en = 1`, `flush = 0`) with real control. It keeps a 3-entry scoreboard of in-flight register writes (EX, MEM, WB), detects RAW and load-use hazards for the instruction in ID, and drives the PC and pipeline-register enables and flushes. It also drives registered forwarding selects for the EX-stage operand muxes and an ID-stage write-through bypass.

## Interface
- `REG_AW`, 5: register-index width; the register file has 2^REG_AW entries.
- `FWD_EN`, 1: 1 = forwarding enabled; 0 = stall-only mode, with every `fwd_*` output held at 0.
- `ZERO_REG`, 1: 1 = register 0 is hardwired zero and never creates a hazard.
- `CNT_W`, 16: width of the performance counters.
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: the ID stage holds a real instruction.
- `id_rs1`, `id_rs2`, in, REG_AW each: source indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`, in, 1 each: the source is actually read.
- `id_rd`, in, REG_AW: destination index of the instruction in ID.
- `id_reg_wr`, in, 1: the instruction in ID writes `id_rd`.
- `id_is_load`, in, 1: the instruction in ID is a load (mem_rd).
- `ex_branch_taken`, in, 1: the EX stage resolves a taken branch or jump (sel3).
- `pc_en`, out, 1: PC register load enable.
- `if_id_en`, out, 1: IF/ID register enable.
- `if_id_flush`, out, 1: clear IF/ID to a bubble.
- `id_ex_flush`, out, 1: load a bubble into ID/EX.
- `fwd_a`, `fwd_b`, out, 2 each: EX operand select. 00 = register file, 01 = MEM ALU result (z_MEM), 10 = WB data (d_in), 11 = never driven.
- `byp_a`, `byp_b`, out, 1 each: in ID, take d_in instead of the register-file read (write-through).
- `stall_cnt`, `flush_cnt`, out, CNT_W each: saturating event counters.

## Operation
- **Scoreboard.** Each entry is {v, rd, ld}, for the stages EX, MEM and WB.
  - Every cycle: WB←MEM and MEM←EX.
  - EX←{id_valid & id_reg_wr, id_rd, id_is_load}, unless `id_ex_flush` = 1, in which case EX←{0, 0, 0}.
  - Entries with rd = 0 are treated as invalid when ZERO_REG = 1.
- **Source match.** `m_S(x)` = id_valid & id_use_x & S.v & (S.rd == id_rx) & !(ZERO_REG & id_rx == 0).
- **Stall condition, FWD_EN = 1.** Stall = any x with m_EX(x) & EX.ld (load-use; one bubble).
- **Stall condition, FWD_EN = 0.** Stall = any x with m_EX(x) | m_MEM(x). A WB match is covered by the write-through bypass.
- **Control outputs, stall only.** pc_en = 0, if_id_en = 0, id_ex_flush = 1, if_id_flush = 0.
- **Control outputs, ex_branch_taken.** pc_en = 1, if_id_en = 1, if_id_flush = 1, id_ex_flush = 1.
  - Branch overrides stall, because the stalled instruction is on the wrong path.
- **Control outputs, otherwise.** pc_en = 1, if_id_en = 1, both flushes 0.
- **Forward select.** Computed in ID and registered into `fwd_*` when ID/EX advances (no stall, no flush).
  - Value = 01 if m_EX(x) & !EX.ld; else 10 if m_MEM(x); else 00.
  - The nearest producer wins.
  - On a stall or flush cycle, `fwd_*` is registered as 00, matching the bubble.
- **Write-through bypass.** `byp_x` = m_WB(x), combinational. Active in both FWD_EN modes.
- **Counters.**
  - `stall_cnt` increments on each cycle where stall = 1 and branch = 0.
  - `flush_cnt` increments on each cycle where `ex_branch_taken` = 1.
  - Both saturate at 2^CNT_W−1.

## Timing
- **Reset (reset = 0, asynchronous).** All scoreboard v = 0, fwd_a = fwd_b = 00, both counters = 0. The combinational outputs then settle to: pc_en = 1, if_id_en = 1, both flushes 0, byp_a = byp_b = 0.
- **Same-cycle outputs.** `pc_en`, `if_id_en`, `if_id_flush`, `id_ex_flush` and `byp_*` are combinational from the inputs and the scoreboard in the same cycle. There is no register between `ex_branch_taken` and the flushes.
- **Forward-select latency.** `fwd_*` is valid in the cycle the instruction occupies EX, one clock after the ID decision.
- **Load-use.** Exactly one stall cycle; the next cycle the load is in MEM, so fwd = 10 is selected after the load moves to WB.
  - Correction: after the stall, the load occupies MEM while the consumer is in ID. The consumer therefore enters EX with fwd = 10 (load in WB, LMD_WB available).
- **Stall-only mode.** A back-to-back dependency costs 2 stall cycles; a distance-2 dependency costs 1.
- **Branch and load-use together.** Branch wins: one flush, no stall counted.
- **Reset mid-stall.** The stall drops immediately and the scoreboard clears.

## Test plan
- **Reset.** Assert reset = 0 mid-run with a stall active. Required: pc_en = 1, id_ex_flush = 0, fwd = 00 and counters = 0 immediately, before any clock edge.
- **EX→EX forward.** Issue ADD r3 followed by SUB r5 = r3 − r1. Required: no stall; fwd_a = 01 in SUB's EX cycle; fwd_b = 00.
- **Load-use.** Issue LW r4 followed by ADD r6 = r4 + r4. Required: exactly one cycle with pc_en = 0 and id_ex_flush = 1; then fwd_a = fwd_b = 10 in ADD's EX cycle; stall_cnt = 1.
- **Write-through and r0.** Issue a write to r7, two unrelated instructions, then a read of r7. Required: byp_a = 1 in the reader's ID cycle. Then issue a write to r0 followed by a read of r0. Required: no stall, fwd = 00, byp = 0.
- **Branch over a stall.** Apply ex_branch_taken = 1 in the same cycle as a load-use match. Required: pc_en = 1, if_id_flush = 1, id_ex_flush = 1; stall_cnt unchanged; flush_cnt +1.
- **FWD_EN = 0, CNT_W = 2.** Issue ADD r3 immediately followed by a read of r3. Required: 2 stall cycles; fwd_* always 00; after 4 or more such stall cycles, stall_cnt saturates at 3.
